// File: rtl/fifo_drain_ctrl_pkg.sv
// Shared constants for the FIFO drain controller: FSM state encodings and
// output skid-buffer sizing.
package fifo_drain_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_BURST = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

    // Output skid buffer holds at most two beats.
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output skid buffer carrying {last, data}.
// Ports:
//   clk, rst_n    - clock, async active-low reset
//   push_i        - write one entry (push_data_i, push_last_i)
//   ready_i       - downstream ready; pop occurs on valid_o && ready_i
//   valid_o       - head entry valid
//   data_o/last_o - head entry payload, stable while stalled
//   count_o       - current occupancy (0..2)
module fifo_skid_buf
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  push_last_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  last_o,
    output logic [SKID_CNT_W-1:0] count_o
);

    localparam int unsigned EW = WIDTH + 1;
    localparam logic [SKID_CNT_W-1:0] CNT_ONE  = SKID_CNT_W'(1);
    localparam logic [SKID_CNT_W-1:0] CNT_FULL = SKID_CNT_W'(SKID_DEPTH);

    logic [EW-1:0]         head_q, head_d;
    logic [EW-1:0]         tail_q, tail_d;
    logic [SKID_CNT_W-1:0] cnt_q, cnt_d;
    logic                  valid_q;
    logic                  pop;
    logic                  full;
    logic [EW-1:0]         in_ent;

    assign pop    = valid_q && ready_i;
    assign full   = (cnt_q == CNT_FULL);
    assign in_ent = {push_last_i, push_data_i};

    // Head always presents the oldest entry; tail only used when two are held.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_i, pop})
            2'b10: begin
                if (cnt_q == '0) begin
                    head_d = in_ent;
                    cnt_d  = cnt_q + CNT_ONE;
                end else if (!full) begin
                    tail_d = in_ent;
                    cnt_d  = cnt_q + CNT_ONE;
                end
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - CNT_ONE;
            end
            2'b11: begin
                if (full) begin
                    head_d = tail_q;
                    tail_d = in_ent;
                end else begin
                    head_d = in_ent;
                end
            end
            default: ;
        endcase
    end

    // Storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d != '0);
        end
    end

    assign valid_o = valid_q;
    assign data_o  = head_q[WIDTH-1:0];
    assign last_o  = head_q[WIDTH];
    assign count_o = cnt_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains an upstream synchronous FIFO in fixed-length bursts (or a shorter
// flush burst) onto a valid/ready stream with a last-beat marker.
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   fifo_empty_i     - upstream FIFO empty flag
//   fifo_cntr_i      - upstream FIFO occupancy
//   fifo_rd_en_c_o   - combinational read enable to the upstream FIFO
//   fifo_data_i      - upstream read data, valid the cycle after a read
//   flush_i          - level request to drain a partial burst
//   m_valid_o/m_ready_i/m_data_o/m_last_o - output beat stream
//   busy_o           - controller is not idle
module fifo_drain_ctrl
    import fifo_drain_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH),
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty_i,
    input  logic [PTR_WIDTH:0]   fifo_cntr_i,
    output logic                 fifo_rd_en_c_o,
    input  logic [WIDTH-1:0]     fifo_data_i,
    input  logic                 flush_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_last_o,
    output logic                 busy_o
);

    localparam int unsigned CNT_W = PTR_WIDTH + 1;
    localparam int unsigned OCC_W = 3;
    localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [STATE_W-1:0]    state_q, state_d;
    logic [CNT_W-1:0]      remain_q, remain_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  busy_q, busy_d;

    logic [SKID_CNT_W-1:0] skid_cnt;
    logic                  pop;
    logic [OCC_W-1:0]      occ;
    logic                  rd_en;

    assign pop = m_valid_o && m_ready_i;

    // Beats already committed to the skid buffer after this cycle's pop;
    // a new read is allowed only if its data is guaranteed a slot.
    assign occ = OCC_W'(skid_cnt) + OCC_W'(inflight_q) - OCC_W'(pop);

    assign rd_en = (state_q == ST_BURST) && (remain_q != '0) && !fifo_empty_i
                   && (occ < OCC_W'(SKID_DEPTH));

    assign fifo_rd_en_c_o = rd_en;

    // Next-state: burst length is latched at the IDLE decision, so later
    // FIFO occupancy changes or flush deassertion cannot alter it.
    always_comb begin
        state_d         = state_q;
        remain_d        = remain_q;
        inflight_d      = rd_en;
        inflight_last_d = rd_en && (remain_q == CNT_ONE);
        case (state_q)
            ST_IDLE: begin
                if (fifo_cntr_i >= BURST_LEN_C) begin
                    state_d  = ST_BURST;
                    remain_d = BURST_LEN_C;
                end else if (flush_i && !fifo_empty_i && (fifo_cntr_i != '0)) begin
                    state_d  = ST_BURST;
                    remain_d = fifo_cntr_i;
                end
            end
            ST_BURST: begin
                if (rd_en) begin
                    remain_d = remain_q - CNT_ONE;
                    if (remain_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (pop && m_last_o) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            remain_q        <= remain_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            busy_q          <= busy_d;
        end
    end

    assign busy_o = busy_q;

    // Read data lands in the skid buffer on the edge after the read.
    fifo_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (inflight_q),
        .push_data_i(fifo_data_i),
        .push_last_i(inflight_last_q),
        .ready_i    (m_ready_i),
        .valid_o    (m_valid_o),
        .data_o     (m_data_o),
        .last_o     (m_last_o),
        .count_o    (skid_cnt)
    );

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width, equal to the upstream sync FIFO WIDTH.
REQ-002 Parameter DEPTH, default 8: upstream FIFO depth.
REQ-003 Parameter PTR_WIDTH, default $clog2(DEPTH): FIFO pointer width.
REQ-004 Parameter BURST_LEN, default 4: beats per burst, legal range 1..DEPTH.
REQ-005 CLK  input  1: single clock; all state changes on its rising edge.
REQ-006 RST  input  1: reset, asynchronous, active-low.
REQ-007 FIFO_EMPTY  input  1: EMPTY flag of the upstream FIFO.
REQ-008 FIFO_CNTR  input  PTR_WIDTH+1: occupancy count of the upstream FIFO.
REQ-009 FIFO_RD_EN  output  1: read enable to the upstream FIFO.
REQ-010 FIFO_DATA  input  WIDTH: DATA_OUT of the upstream FIFO, valid in the cycle after the edge that sampled FIFO_RD_EN=1.
REQ-011 FLUSH  input  1: level request to drain residual data below BURST_LEN.
REQ-012 M_VALID  output  1: output beat valid.
REQ-013 M_READY  input  1: downstream accepts the beat.
REQ-014 M_DATA  output  WIDTH: output beat data.
REQ-015 M_LAST  output  1: final beat of the current burst, qualified by M_VALID.
REQ-016 BUSY  output  1: high whenever the FSM is not IDLE.

Function
REQ-017 FSM states IDLE, BURST, DONE; encoded in 2 bits.
REQ-018 IDLE->BURST when FIFO_CNTR >= BURST_LEN; burst length = BURST_LEN.
REQ-019 IDLE->BURST when FLUSH=1 and FIFO_EMPTY=0 and FIFO_CNTR < BURST_LEN; burst length = FIFO_CNTR sampled at that edge.
REQ-020 BURST: issue exactly burst-length reads, then -> DONE; DONE -> IDLE on the edge where the M_LAST beat handshakes (M_VALID && M_READY).
REQ-021 FIFO_RD_EN is combinational and SHALL be 1 only when state=BURST, reads remaining > 0, FIFO_EMPTY=0, and (buffered + in-flight - (M_VALID&&M_READY)) < 2.
REQ-022 FIFO_RD_EN SHALL never be 1 while FIFO_EMPTY=1, including the cycle a write arrives into an empty FIFO.
REQ-023 Read latency: FIFO_RD_EN sampled at edge N -> FIFO_DATA captured at edge N+1 -> M_VALID=1 from edge N+1 onward.
REQ-024 Sustained throughput with M_READY=1 SHALL be one beat per cycle.
REQ-025 Output uses a 2-entry skid buffer; M_DATA and M_LAST SHALL hold stable while M_VALID=1 and M_READY=0.
REQ-026 Beats emerge in FIFO read order; no beat dropped or duplicated under any M_READY pattern.
REQ-027 M_LAST=1 on exactly the burst-length-th beat of each burst and on no other beat.
REQ-028 Reads-remaining counter width PTR_WIDTH+1, decremented per issued read, never wraps below 0.
REQ-029 FLUSH deasserting mid-burst SHALL NOT shorten a burst already started.
REQ-030 FIFO_CNTR changes during BURST (concurrent writes) SHALL NOT alter the current burst length.
REQ-031 After DONE->IDLE, a new burst may start on the immediately following edge.

Reset
REQ-032 RST low SHALL immediately force state=IDLE, M_VALID=0, M_DATA=0, M_LAST=0, BUSY=0, FIFO_RD_EN=0, skid buffer empty, counters 0.
REQ-033 Reset asserted mid-burst discards buffered and in-flight beats; no beat emerges after reset release without a fresh IDLE->BURST decision.

Structure
REQ-034 FSM state encodings and the skid-buffer depth constant (2) SHALL reside in shared header fifo_defs.vh.
REQ-035 Skid buffer SHALL be a sub-module named fifo_skid_buf (WIDTH+1 bits: data plus last flag).
REQ-036 Implementation SHALL be 120-400 lines of RTL, synthesizable, no latches.

Verification
REQ-037 Reset: RST low mid-burst -> M_VALID=0, BUSY=0, FIFO_RD_EN=0 in the same cycle.
REQ-038 Push 10,20,30,40 into DEPTH=8 FIFO, M_READY=1 -> 4 consecutive beats 10,20,30,40, M_LAST on 40, BUSY then 0.
REQ-039 Push 5,6 (FIFO_CNTR=2), FLUSH=1 one cycle -> beats 5,6, M_LAST on 6; no read with FIFO_EMPTY=1.
REQ-040 Push 8 values, M_READY toggling 1,0,0,1 repeating -> two bursts of 4, order preserved, M_DATA stable during stalls.
REQ-041 Push 4 values, start burst, push 4 more during BURST -> first burst exactly 4 beats; second burst starts the edge after DONE->IDLE.
REQ-042 Scoreboard on every test: sequence out equals sequence written; FIFO_RD_EN && FIFO_EMPTY never true.
